// File: rtl/dump_pkg.sv
// Shared types and constants for the CPU state dump block: FSM states,
// the register-file dump order and the layout of the stream tag.
package dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RF_DUMP = 2'd1,
        ST_DM_DUMP = 2'd2,
        ST_DONE    = 2'd3
    } dump_state_t;

    localparam int RF_COUNT = 14;

    localparam logic [4:0] RF_LIST [RF_COUNT] = '{
        5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
        5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd29, 5'd31
    };

    localparam int TAG_W        = 8;
    localparam int TAG_KIND_BIT = 7;
    localparam int TAG_IDX_W    = 7;
    localparam int IDX_W        = 7;

    // Tag bit 7 selects memory (1) versus register (0); low bits carry the index.
    function automatic logic [TAG_W-1:0] make_tag(input logic           is_mem,
                                                   input logic [TAG_IDX_W-1:0] idx);
        logic [TAG_W-1:0] tag;
        tag                  = '0;
        tag[TAG_KIND_BIT]    = is_mem;
        tag[TAG_IDX_W-1:0]   = idx;
        return tag;
    endfunction

endpackage

// File: rtl/dump_stream_reg.sv
// Single-entry valid/ready output register for the dump stream. The slot is
// free when empty or being drained; loads are only taken into a free slot.
module dump_stream_reg
    import dump_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_free,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [TAG_W-1:0]  r_tag;
    logic              r_last;

    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_tag   = r_tag;
    assign o_last  = r_last;

    // Payload only changes on a load into a free slot, so it holds while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tag   <= '0;
            r_last  <= 1'b0;
        end else if (i_load && o_free) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_tag   <= i_tag;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_state_dump.sv
// Counts cycles after reset, then halts the CPU and streams a fixed list of
// register-file entries followed by the first DM_WORDS data-memory words.
module cpu_state_dump
    import dump_pkg::*;
#(
    parameter int END_COUNT = 600,
    parameter int DM_WORDS  = 12,
    parameter int DATA_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dump_req_i,
    output logic              cpu_halt_o,
    output logic [4:0]        rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [31:0]       dm_addr_o,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [7:0]        dump_tag_o,
    output logic              dump_last_o,
    output logic              done_o
);

    localparam logic [31:0]      HIT_COUNT   = 32'(END_COUNT - 1);
    localparam logic [IDX_W-1:0] RF_LAST_IDX = IDX_W'(RF_COUNT - 1);
    localparam logic [IDX_W-1:0] DM_LAST_IDX = IDX_W'(DM_WORDS - 1);
    localparam logic [IDX_W-1:0] DM_END_IDX  = IDX_W'(DM_WORDS);

    dump_state_t       r_state;
    logic [31:0]       r_count;
    logic [IDX_W-1:0]  r_idx;
    logic              r_halt;
    logic              r_done;

    logic              w_trigger;
    logic              w_free;
    logic              w_load;
    logic [DATA_W-1:0] w_cap_data;
    logic [TAG_W-1:0]  w_cap_tag;
    logic              w_cap_last;
    logic              w_last_accept;

    assign w_trigger     = (r_count == HIT_COUNT) || dump_req_i;
    assign w_last_accept = dump_valid_o && dump_ready_i && dump_last_o;
    assign cpu_halt_o    = r_halt;
    assign done_o        = r_done;

    // Debug read addresses and the capture payload for the current index.
    always_comb begin
        rf_addr_o  = '0;
        dm_addr_o  = '0;
        w_load     = 1'b0;
        w_cap_data = '0;
        w_cap_tag  = '0;
        w_cap_last = 1'b0;
        case (r_state)
            ST_RF_DUMP: begin
                rf_addr_o  = RF_LIST[r_idx[3:0]];
                w_load     = w_free;
                w_cap_data = rf_data_i;
                w_cap_tag  = make_tag(1'b0, {2'b00, RF_LIST[r_idx[3:0]]});
            end
            ST_DM_DUMP: begin
                if (r_idx != DM_END_IDX) begin
                    dm_addr_o  = {{(32-IDX_W-2){1'b0}}, r_idx, 2'b00};
                    w_load     = w_free;
                    w_cap_data = dm_data_i;
                    w_cap_tag  = make_tag(1'b1, r_idx);
                    w_cap_last = (r_idx == DM_LAST_IDX);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_halt  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_count <= r_count + 32'd1;
                    if (w_trigger) begin
                        r_state <= ST_RF_DUMP;
                        r_idx   <= '0;
                        r_halt  <= 1'b1;
                    end
                end
                ST_RF_DUMP: begin
                    if (w_load) begin
                        if (r_idx == RF_LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= ST_DM_DUMP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DM_DUMP: begin
                    // Index parks at DM_WORDS after the last capture until it drains.
                    if (w_load) begin
                        r_idx <= r_idx + 1'b1;
                    end
                    if (w_last_accept) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dump_stream_reg #(
        .DATA_W(DATA_W)
    ) u_stream (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_load),
        .i_data  (w_cap_data),
        .i_tag   (w_cap_tag),
        .i_last  (w_cap_last),
        .i_ready (dump_ready_i),
        .o_free  (w_free),
        .o_valid (dump_valid_o),
        .o_data  (dump_data_o),
        .o_tag   (dump_tag_o),
        .o_last  (dump_last_o)
    );

endmodule

// File: tb/tb_cpu_state_dump.sv
// Bench for cpu_state_dump: scenario table with a stream scoreboard and a
// ready-pattern latency model, plus a small-memory sequence on a second instance.
module tb_cpu_state_dump;

    localparam int END_COUNT  = 600;
    localparam int DM_WORDS   = 12;
    localparam int N_WORDS    = 14 + DM_WORDS;
    localparam int END_COUNT1 = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        ready = 1'b0;
    logic        halt, valid, last, done;
    logic [4:0]  rf_addr;
    logic [31:0] dm_addr, rf_data, dm_data, data;
    logic [7:0]  tag;

    logic        rst1 = 1'b1;
    logic        req1 = 1'b0;
    logic        ready1 = 1'b1;
    logic        halt1, valid1, last1, done1;
    logic [4:0]  rf_addr1;
    logic [31:0] dm_addr1, rf_data1, dm_data1, data1;
    logic [7:0]  tag1;

    logic [31:0] rf_mem [32];
    logic [31:0] dm_mem [128];

    assign rf_data  = rf_mem[rf_addr];
    assign dm_data  = (dm_addr < 32'd512) ? dm_mem[dm_addr[8:2]] : 32'hDEAD_BEEF;
    assign rf_data1 = rf_mem[rf_addr1];
    assign dm_data1 = (dm_addr1 < 32'd512) ? dm_mem[dm_addr1[8:2]] : 32'hDEAD_BEEF;

    cpu_state_dump #(.END_COUNT(END_COUNT), .DM_WORDS(DM_WORDS), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .dump_req_i(req), .cpu_halt_o(halt),
        .rf_addr_o(rf_addr), .rf_data_i(rf_data), .dm_addr_o(dm_addr), .dm_data_i(dm_data),
        .dump_valid_o(valid), .dump_ready_i(ready), .dump_data_o(data), .dump_tag_o(tag),
        .dump_last_o(last), .done_o(done)
    );

    cpu_state_dump #(.END_COUNT(END_COUNT1), .DM_WORDS(1), .DATA_W(32)) dut1 (
        .clk_i(clk), .rst_i(rst1), .dump_req_i(req1), .cpu_halt_o(halt1),
        .rf_addr_o(rf_addr1), .rf_data_i(rf_data1), .dm_addr_o(dm_addr1), .dm_data_i(dm_data1),
        .dump_valid_o(valid1), .dump_ready_i(ready1), .dump_data_o(data1), .dump_tag_o(tag1),
        .dump_last_o(last1), .done_o(done1)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [40:0] exp_q[$];

    int tb_rf_list [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 29, 31};

    typedef struct {
        bit do_reset;
        int req_cycle;
        int req2_cycle;
        int ready_mode;   // 0 always high, 1 toggling (high at k+2), 2 random
        int abort_edge;   // edge at which reset is sampled mid-dump, 0 = none
        bit rand_mem;
        int exp_k;        // edge that raises halt
        int exp_lat;      // done edge minus exp_k, -1 = derive from ready pattern
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string ctx);
        check({ctx, " halt"},    64'(halt),    64'd0);
        check({ctx, " valid"},   64'(valid),   64'd0);
        check({ctx, " done"},    64'(done),    64'd0);
        check({ctx, " last"},    64'(last),    64'd0);
        check({ctx, " data"},    64'(data),    64'd0);
        check({ctx, " tag"},     64'(tag),     64'd0);
        check({ctx, " rf_addr"}, 64'(rf_addr), 64'd0);
        check({ctx, " dm_addr"}, 64'(dm_addr), 64'd0);
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 32; i++)  rf_mem[i] = rnd ? $urandom : 32'(i * 3);
        for (int j = 0; j < 128; j++) dm_mem[j] = rnd ? $urandom : 32'(100 + j);
    endtask

    task automatic build_expected(input int n_dm);
        exp_q.delete();
        for (int i = 0; i < 14; i++)
            exp_q.push_back({1'b0, 8'(tb_rf_list[i]), rf_mem[tb_rf_list[i]]});
        for (int j = 0; j < n_dm; j++)
            exp_q.push_back({(j == n_dm - 1), 8'h80 | 8'(j), dm_mem[j]});
    endtask

    task automatic run_vec(input vec_t v);
        bit          rdy [1024];
        int          lat, limit, cnt, k_seen, done_seen;
        logic        p_valid;
        logic [40:0] p_word, e;

        fill_mem(v.rand_mem);
        build_expected(DM_WORDS);
        for (int n = 0; n < 1024; n++) begin
            case (v.ready_mode)
                0:       rdy[n] = 1'b1;
                1:       rdy[n] = ((n - v.exp_k) % 2 == 0);
                default: rdy[n] = 1'($urandom_range(0, 1));
            endcase
        end
        // The first word is valid from k+1; each ready-high edge after that drains one word.
        lat = v.exp_lat;
        if (lat < 0) begin
            cnt = 0;
            lat = 1000;
            for (int n = v.exp_k + 2; n < 1024; n++) begin
                if (rdy[n]) cnt++;
                if (cnt == N_WORDS) begin
                    lat = n - v.exp_k;
                    break;
                end
            end
        end
        limit = v.exp_k + lat + 4;
        if (limit > 1023) limit = 1023;

        if (v.do_reset) begin
            rst = 1'b1; req = 1'b0; ready = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check_reset_outputs("reset");
        end

        p_valid = 1'b0; p_word = '0; k_seen = -1; done_seen = -1;
        for (int n = 1; n <= limit; n++) begin
            ready = rdy[n];
            req   = (n == v.req_cycle) || (n == v.req2_cycle);
            rst   = (v.abort_edge != 0) && (n == v.abort_edge);
            if (p_valid && ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(p_word), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 64'(p_word), 64'(e));
                end
            end
            @(posedge clk);
            @(negedge clk);
            if (rst) begin
                check_reset_outputs("abort");
                exp_q.delete();
                rst = 1'b0;
                return;
            end
            if (p_valid && !ready)
                check("stall_hold", 64'({last, tag, data}), 64'(p_word));
            if (halt && k_seen < 0) k_seen = n;
            if (done && done_seen < 0) done_seen = n;
            p_valid = valid;
            p_word  = {last, tag, data};
            if (done_seen >= 0 && n >= done_seen + 2) break;
        end
        req = 1'b0;
        check("halt_edge", 64'(k_seen), 64'(v.exp_k));
        check("done_latency", 64'(done_seen - v.exp_k), 64'(lat));
        check("words_left", 64'(exp_q.size()), 64'd0);
        check("done_state", 64'({halt, valid, done}), 64'b101);
    endtask

    task automatic run_small();
        logic [40:0] got[$];
        logic [40:0] e;
        int          k_seen, done_seen;

        fill_mem(1'b0);
        build_expected(1);
        rst1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("small_reset", 64'({halt1, valid1, done1, last1, tag1}), 64'd0);
        rst1 = 1'b0;
        k_seen = -1; done_seen = -1;
        for (int n = 1; n <= END_COUNT1 + 24; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid1) got.push_back({last1, tag1, data1});
            if (halt1 && k_seen < 0) k_seen = n;
            if (done1 && done_seen < 0) done_seen = n;
        end
        check("small_halt_edge", 64'(k_seen), 64'(END_COUNT1));
        check("small_done_edge", 64'(done_seen), 64'(END_COUNT1 + 16));
        check("small_word_count", 64'(got.size()), 64'd15);
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front();
            check("small_word", 64'(got.pop_front()), 64'(e));
        end
    endtask

    initial begin
        int r;
        r = $urandom_range(3, 200);
        //          rst   req  req2 mode abort rnd   k    lat
        vecs[0] = '{1'b1, 0,   0,   0,   0,    1'b0, 600, 27};
        vecs[1] = '{1'b1, 20,  25,  0,   0,    1'b0, 20,  27};
        vecs[2] = '{1'b1, 20,  0,   1,   0,    1'b0, 20,  52};
        vecs[3] = '{1'b1, 5,   0,   0,   26,   1'b0, 5,   -1};
        vecs[4] = '{1'b0, 0,   0,   0,   0,    1'b0, 600, 27};
        vecs[5] = '{1'b1, 600, 0,   0,   0,    1'b0, 600, 27};
        vecs[6] = '{1'b1, r,   0,   2,   0,    1'b1, r,   -1};
        vecs[7] = '{1'b1, 0,   0,   2,   0,    1'b1, 600, -1};

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        run_small();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_state_dump.md
# cpu_state_dump

Hardware end of the CPU result-reporting interface: rather than a bench peeking into the register file and data memory hierarchically, this block counts cycles after reset, then at a fixed cycle count (or on request) freezes the CPU. It reads a fixed list of register-file entries and data-memory words through debug read ports and streams them out over a valid/ready word stream. It sits beside `Simple_Single_CPU`, sharing its clock. It drives the CPU halt input and the debug read addresses of the register file and the data memory.

## Interface
- `END_COUNT`, 600: cycle count after reset release at which the dump triggers automatically (≥2).
- `DM_WORDS`, 12: number of data-memory words dumped, byte addresses 0x0, 0x4, … 4·(DM_WORDS−1); range 1..127.
- `DATA_W`, 32: data word width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, **synchronous, active-high**.
- `dump_req_i` in 1: early dump request, single-cycle pulse; honoured only in IDLE.
- `cpu_halt_o` out 1: freezes CPU PC/register/memory writes while high.
- `rf_addr_o` out 5: register-file debug read address.
- `rf_data_i` in DATA_W: register-file debug read data, combinational from `rf_addr_o`.
- `dm_addr_o` out 32: data-memory debug byte address.
- `dm_data_i` in DATA_W: data-memory debug read data, combinational from `dm_addr_o`.
- `dump_valid_o` out 1: stream word valid.
- `dump_ready_i` in 1: stream consumer ready.
- `dump_data_o` out DATA_W: stream word.
- `dump_tag_o` out 8: bit7 = 0 for a register, 1 for memory. Bits 6:0 hold the register number or the memory word index.
- `dump_last_o` out 1: marks the final word of the dump.
- `done_o` out 1: dump complete, held until reset.

## Operation
- FSM states: IDLE, RF_DUMP, DM_DUMP, DONE.
- IDLE: a 32-bit cycle counter increments every cycle. Leave IDLE when `counter == END_COUNT−1` or when `dump_req_i` = 1. A coincident count hit and request produce one dump. On leaving, clear the index and go to RF_DUMP.
- RF_DUMP: walk the package table `RF_LIST` = {0,1,2,3,4,5,6,7,8,9,10,11,29,31} (14 entries).
  - `rf_addr_o = RF_LIST[idx]` combinationally.
  - The output slot is free when `!dump_valid_o || dump_ready_i`. When the slot is free, capture `rf_data_i` into `dump_data_o`, set the tag to {0, RF_LIST[idx]}, set valid, and increment `idx`.
  - After capturing entry 13, clear `idx` and go to DM_DUMP.
- DM_DUMP: same rules, with `dm_addr_o = {idx, 2'b00}` and tag {1, idx}.
  - The capture of word DM_WORDS−1 also sets `dump_last_o`.
  - When that last word is accepted (valid && ready), go to DONE.
- DONE: `dump_valid_o` = 0, `done_o` = 1, `cpu_halt_o` stays 1. Remains in DONE until reset.
- `cpu_halt_o` = 1 in every state except IDLE.
- `dump_req_i` is ignored outside IDLE.
- `rf_addr_o` and `dm_addr_o` are 0 whenever they are not in use.
- Stream rule: `dump_data_o`, `dump_tag_o` and `dump_last_o` stay stable while valid && !ready.

## Timing
- Reset: state IDLE, counter 0, index 0. All outputs are 0.
- Reset in any state, including mid-dump, aborts the dump and returns everything to the reset values on the next edge.
- Trigger: a count hit or request sampled at edge k gives `cpu_halt_o` = 1 from edge k (registered state). The CPU therefore executes exactly END_COUNT cycles after reset release.
- The first word is valid from edge k+1.
- With `dump_ready_i` held high: one word per cycle, 14 + DM_WORDS words on edges k+1 … k+14+DM_WORDS, and `done_o` = 1 one edge after the last word.
- Backpressure: each cycle with ready low stalls the index and holds the data. Total latency grows by exactly the stall count.
- Read data is sampled on the capturing edge only. Because the CPU is halted, these values are consistent.

## Structure
- Package `dump_pkg`: the state enum, `RF_LIST` constant array, `RF_COUNT` = 14, and tag field positions.
- One natural sub-module: `dump_stream_reg`, the valid/ready output register holding data, tag and last, with free-slot logic. The FSM and counter live in the top module.

## Test plan
- Reset release, ready held 1, no request, RF[i] = i·3, mem[j] = 100 + j → halt at cycle 600. Expect 26 words in order: tags 0x00–0x0B, 0x1D, 0x1F with data 0,3,…,33,87,93; then tags 0x80–0x8B with data 100–111. `dump_last_o` only on tag 0x8B; `done_o` the next cycle.
- `dump_req_i` pulse at cycle 20 → halt from cycle 20 and the same sequence. A second pulse at cycle 25 changes nothing.
- Ready toggled 1/0 each cycle → data and tag stable while stalled; no word lost or duplicated; `done_o` 25 cycles later than in the ready-high case.
- `rst_i` asserted during DM_DUMP word 5 → the next edge gives all outputs 0 and halt released. The count restarts and a full dump recurs at 600 cycles after release.
- Count hit and `dump_req_i` in the same cycle → exactly one 26-word dump.
- `DM_WORDS` = 1 → the memory phase emits only tag 0x80 with `dump_last_o` = 1.
